keypad_key_arbiter: RTL and testbench
=====================================

Name: keypad_key_arbiter

Overview:
Sits between the keypad scanner and key consumers such as the display driver and the command decoder. Completes the scanner's KeyRdy/KeyRd handshake and buffers captured RowColVector codes in a small FIFO. Serves buffered keys to NREQ requesters through a round-robin arbiter. Frees the scanner to resume scanning as soon as a key is buffered, independent of consumer latency.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
NREQ, 2, number of requesters, 1 to 4.
DROP_WHEN_FULL, 0, 0 = stall handshake while full; 1 = ack, discard key, set Overflow.

Ports:
Clock  in  1  system clock, rising edge.
Reset  in  1  synchronous, active-high reset.
KeyRdy  in  1  scanner has a key on RowColVector.
RowColVector  in  4  scanner key code {row,col}.
KeyRd  out  1  acknowledge to scanner.
Req  in  NREQ  per-requester key request; level, held until granted.
Gnt  out  NREQ  one-hot grant, 1-cycle pulse.
KeyOut  out  4  key code, valid when any Gnt bit is set.
KeyValid  out  1  OR of Gnt.
Count  out  clog2(DEPTH)+1  FIFO occupancy.
Overflow  out  1  sticky; a key was dropped.
OvfClr  in  1  clears Overflow.

Behaviour:
- Reset (synchronous, active-high; Clock and Reset as named above). Outputs and state on reset:
  - KeyRd=0, Gnt=0, KeyValid=0, KeyOut=4'b0000, Count=0, Overflow=0.
  - FIFO pointers=0, round-robin pointer=0, handshake FSM=IDLE.
- Reset asserted mid-handshake: returns FSM to IDLE with KeyRd=0. The scanner is left holding KeyRdy, so the key is re-captured after reset.
- Handshake FSM, all outputs registered:
  - IDLE: when KeyRdy=1 and Count<DEPTH, push RowColVector, KeyRd<=1, go to ACK.
  - IDLE, KeyRdy=1, Count==DEPTH, DROP_WHEN_FULL=1: no push, Overflow<=1, KeyRd<=1, go to ACK.
  - IDLE, KeyRdy=1, Count==DEPTH, DROP_WHEN_FULL=0: stay in IDLE, KeyRd=0 (scanner stalls).
  - ACK: hold KeyRd=1 until KeyRdy is sampled 0, then KeyRd<=0 and go to IDLE.
  - Exactly one push per KeyRdy assertion.
- Full test uses Count at the start of the cycle. A pop in the same cycle does not enable a push; the push happens the next cycle.
- Arbiter:
  - Each cycle with Count>0 and Req!=0, grant the first requesting index at or after the RR pointer, wrapping at NREQ.
  - Registered: Gnt, KeyOut=FIFO head, and pop all take effect at the same edge. Gnt visible 1 cycle after Req and non-empty are sampled.
  - RR pointer <= granted index+1, modulo NREQ.
  - Requester must deassert Req in the cycle after seeing Gnt, or it is eligible again.
  - Count==0: no grant. There is no bypass, so a key pushed at edge N can be granted at edge N+1 at the earliest.
- Simultaneous push and pop: Count unchanged, both pointers advance.
- Wrap-around: pointers are clog2(DEPTH) bits and wrap naturally; Count distinguishes full from empty.
- Overflow: set on drop, cleared by OvfClr; set wins if both occur in the same cycle. Never set when DROP_WHEN_FULL=0.
- KeyOut holds its last value when Gnt=0.

Optional Feature:
KEYPAD_DUP_FILTER_EN
- Defined: a key equal to the last pushed code is acked but not pushed if it arrives within 1023 cycles of the previous push. A 10-bit hold counter restarts on each push and saturates at 1023. Reset clears the last-code-valid flag.
- Undefined: every acked key is pushed; no counter or last-code register is present.

Decomposition:
- Shared package keypad_pkg holds:
  - Handshake FSM state encoding: IDLE=1'b0, ACK=1'b1.
  - KEY_W=4.
  - Dup-filter hold constant 1023.
- Natural sub-module: keypad_rr_arbiter (NREQ-wide round-robin, request/pointer in, one-hot grant out), reusable elsewhere. The FIFO stays inline.

Test Plan:
1. Reset; scanner model raises KeyRdy with code 4'b0110. Expect KeyRd=1 next cycle and held until KeyRdy falls. Then Count=1; Req=2'b01 gives Gnt=2'b01, KeyOut=4'b0110, Count=0.
2. Push 4 keys (0,1,2,3) with no Req, then a fifth key, DROP_WHEN_FULL=0. Expect KeyRd stays 0 and Count=4. Assert Req=01: KeyOut 0, then 1, 2, 3. After the first pop the fifth key is accepted, so Count returns to 4 after the pop/push cycle.
3. Same fill as scenario 2 with DROP_WHEN_FULL=1. The fifth key is acked, Overflow=1, Count=4. Pulsing OvfClr gives Overflow=0.
4. FIFO holds 3 keys, Req=2'b11 held continuously with each requester dropping Req for one cycle after its grant. Expect Gnt order 01, 10, 01 and KeyOut in FIFO order.
5. Count=2 with push and pop in the same cycle: Count stays 2; the next pops return the older key first.
6. With KEYPAD_DUP_FILTER_EN defined, key 4'b1001 is sent twice, 10 cycles apart: both are acked and Count=1. A third 4'b1001 after 1100 cycles is pushed, giving Count=2.

Source files
------------

// File: rtl/keypad_key_arbiter_pkg.sv
// Shared definitions for the keypad key arbiter: key code width,
// handshake state encoding and the duplicate-filter hold limit.
package keypad_pkg;

    // Width of a {row,col} key code from the scanner.
    localparam int KEY_W = 4;

    // Duplicate-filter hold counter width and its saturation value.
    localparam int               DUP_HOLD_W = 10;
    localparam logic [DUP_HOLD_W-1:0] DUP_HOLD   = 10'd1023;

    // Scanner handshake states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } hs_state_t;

endpackage

// File: rtl/keypad_key_arbiter_if.sv
// Bus bundle between the keypad scanner / key consumers and the arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface keypad_key_arbiter_if #(
    parameter int NREQ  = 2,
    parameter int DEPTH = 4
);
    import keypad_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic             KeyRdy;
    logic [KEY_W-1:0] RowColVector;
    logic             KeyRd;
    logic [NREQ-1:0]  Req;
    logic [NREQ-1:0]  Gnt;
    logic [KEY_W-1:0] KeyOut;
    logic             KeyValid;
    logic [CW-1:0]    Count;
    logic             Overflow;
    logic             OvfClr;

    modport slave (
        input  KeyRdy, RowColVector, Req, OvfClr,
        output KeyRd, Gnt, KeyOut, KeyValid, Count, Overflow
    );

    modport master (
        output KeyRdy, RowColVector, Req, OvfClr,
        input  KeyRd, Gnt, KeyOut, KeyValid, Count, Overflow
    );

endinterface

// File: rtl/keypad_key_arbiter_rr_arbiter.sv
// NREQ-wide round-robin arbiter: grants the first requester at or after
// the pointer, wrapping at NREQ. Purely combinational; the caller owns
// the pointer register.
module keypad_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt
);

    // Index of the requester examined i positions after the pointer.
    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] p, input int i);
        int s;
        s = int'(p) + i;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return PW'(s);
    endfunction

    logic found;

    // Scan from the pointer and grant the first active request.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[wrap_idx(ptr, i)]) begin
                gnt[wrap_idx(ptr, i)] = 1'b1;
                found                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/keypad_key_arbiter.sv
// Keypad key arbiter: completes the scanner KeyRdy/KeyRd handshake,
// buffers key codes in a DEPTH-entry FIFO and hands them out to NREQ
// requesters through a round-robin arbiter.
// Optional feature macro: KEYPAD_DUP_FILTER_EN (repeat-key suppression).
module keypad_key_arbiter
    import keypad_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int NREQ           = 2,
    parameter int DROP_WHEN_FULL = 0
) (
    input  logic                 Clock,
    input  logic                 Reset,
    keypad_key_arbiter_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

    hs_state_t        state;
    hs_state_t        state_next;
    logic             key_rd;
    logic             key_rd_next;
    logic             push;
    logic             drop;
    logic             dup_hit;
    logic             full;

    logic [KEY_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic             pop;
    logic [NREQ-1:0]  rr_gnt;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    gnt_idx;
    logic [NREQ-1:0]  gnt;
    logic [KEY_W-1:0] key_out;
    logic             ovf;

    // Binary index of a one-hot grant vector.
    function automatic logic [PW-1:0] onehot_idx(input logic [NREQ-1:0] oh);
        logic [PW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) begin
                idx = idx | PW'(i);
            end
        end
        return idx;
    endfunction

    // Fullness is judged on the occupancy at the start of the cycle, so a
    // pop in the same cycle never makes room for a push until the next one.
    assign full = (count == FULL_CNT);

`ifdef KEYPAD_DUP_FILTER_EN
    logic [KEY_W-1:0]      last_code;
    logic                  last_vld;
    logic [DUP_HOLD_W-1:0] hold_cnt;

    // Hold counter restarts on every push and saturates at the hold limit.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            last_vld <= 1'b0;
            hold_cnt <= '0;
        end else if (push) begin
            last_vld <= 1'b1;
            hold_cnt <= '0;
        end else if (hold_cnt != DUP_HOLD) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    // Remember the most recently buffered code.
    always_ff @(posedge Clock) begin
        if (push) begin
            last_code <= bus.RowColVector;
        end
    end

    // A repeat of the last buffered code inside the hold window is acked only.
    assign dup_hit = last_vld && (bus.RowColVector == last_code) && (hold_cnt != DUP_HOLD);
`else
    assign dup_hit = 1'b0;
`endif

    // Handshake state and KeyRd register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state  <= ST_IDLE;
            key_rd <= 1'b0;
        end else begin
            state  <= state_next;
            key_rd <= key_rd_next;
        end
    end

    // Handshake next state: accept, drop or stall a new key; release on KeyRdy low.
    always_comb begin
        state_next  = state;
        key_rd_next = key_rd;
        push        = 1'b0;
        drop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.KeyRdy) begin
                    if (!full) begin
                        push        = !dup_hit;
                        key_rd_next = 1'b1;
                        state_next  = ST_ACK;
                    end else if (DROP_WHEN_FULL != 0) begin
                        drop        = 1'b1;
                        key_rd_next = 1'b1;
                        state_next  = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                if (!bus.KeyRdy) begin
                    key_rd_next = 1'b0;
                    state_next  = ST_IDLE;
                end
            end
        endcase
    end

    // One pop per cycle whenever a key is buffered and anyone is asking.
    assign pop = (count != '0) && (|bus.Req);

    keypad_rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr (
        .req (bus.Req),
        .ptr (rr_ptr),
        .gnt (rr_gnt)
    );

    assign gnt_idx = onehot_idx(rr_gnt);

    // FIFO storage write; contents need no reset.
    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wr_ptr] <= bus.RowColVector;
        end
    end

    // FIFO pointers wrap naturally; the occupancy count separates full from empty.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Grant, head key and round-robin pointer all update at the pop edge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            gnt     <= '0;
            key_out <= '0;
            rr_ptr  <= '0;
        end else begin
            gnt <= pop ? rr_gnt : '0;
            if (pop) begin
                key_out <= mem[rd_ptr];
                rr_ptr  <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    // Sticky overflow flag; a drop in the same cycle beats a clear.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (bus.OvfClr) begin
            ovf <= 1'b0;
        end
    end

    assign bus.KeyRd    = key_rd;
    assign bus.Gnt      = gnt;
    assign bus.KeyOut   = key_out;
    assign bus.KeyValid = |gnt;
    assign bus.Count    = count;
    assign bus.Overflow = ovf;

endmodule

// File: tb/tb_keypad_key_arbiter.sv
// Bench for keypad_key_arbiter: two instances (stall-when-full and
// drop-when-full) checked every cycle against a queue-based model, plus
// directed literal expectations for each scenario.
module tb_keypad_key_arbiter;
    import keypad_pkg::*;

    localparam int DEPTH = 4;
    localparam int NREQ  = 2;

`ifdef KEYPAD_DUP_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    keypad_key_arbiter_if #(.NREQ(NREQ), .DEPTH(DEPTH)) b0 ();
    keypad_key_arbiter_if #(.NREQ(NREQ), .DEPTH(DEPTH)) b1 ();

    keypad_key_arbiter #(.DEPTH(DEPTH), .NREQ(NREQ), .DROP_WHEN_FULL(0)) dut0 (
        .Clock (clk),
        .Reset (rst),
        .bus   (b0.slave)
    );

    keypad_key_arbiter #(.DEPTH(DEPTH), .NREQ(NREQ), .DROP_WHEN_FULL(1)) dut1 (
        .Clock (clk),
        .Reset (rst),
        .bus   (b1.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         keyrd;
        logic [1:0] gnt;
        logic [3:0] keyout;
        bit         ovf;
        int         rr;
        logic [3:0] last;
        bit         lastv;
        int         since;
    } mstate_t;

    mstate_t    m0, m1;
    logic [3:0] mq0[$];
    logic [3:0] mq1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one clock edge of the arbiter's rules.
    task automatic model_step(inout mstate_t s, inout logic [3:0] q[$], input bit dropmode,
                              input logic rdy, input logic [3:0] code,
                              input logic [1:0] req, input logic clr);
        int  pick;
        int  j;
        int  cnt;
        bit  do_push;
        bit  dropped;
        if (rst) begin
            s.keyrd  = 0;
            s.gnt    = 2'b00;
            s.keyout = 4'h0;
            s.ovf    = 0;
            s.rr     = 0;
            s.last   = 4'h0;
            s.lastv  = 0;
            s.since  = 0;
            q.delete();
            return;
        end
        cnt     = q.size();
        pick    = -1;
        do_push = 0;
        dropped = 0;
        if (cnt > 0 && req != 2'b00) begin
            for (int i = 0; i < NREQ; i++) begin
                j = (s.rr + i) % NREQ;
                if (pick < 0 && ((int'(req) >> j) & 1) == 1) pick = j;
            end
        end
        if (!s.keyrd) begin
            if (rdy) begin
                if (cnt < DEPTH) begin
                    if (!(FILT && s.lastv && code == s.last && s.since < 1023)) do_push = 1;
                    s.keyrd = 1;
                end else if (dropmode) begin
                    dropped = 1;
                    s.keyrd = 1;
                end
            end
        end else if (!rdy) begin
            s.keyrd = 0;
        end
        if (dropped) s.ovf = 1;
        else if (clr) s.ovf = 0;
        if (pick >= 0) begin
            s.gnt    = 2'(1 << pick);
            s.keyout = q.pop_front();
            s.rr     = (pick + 1) % NREQ;
        end else begin
            s.gnt = 2'b00;
        end
        if (do_push) begin
            q.push_back(code);
            s.last  = code;
            s.lastv = 1;
            s.since = 0;
        end else if (s.since < 1023) begin
            s.since++;
        end
    endtask

    task automatic compare_all();
        check("i0_keyrd",  b0.KeyRd,    m0.keyrd);
        check("i0_gnt",    b0.Gnt,      m0.gnt);
        check("i0_keyout", b0.KeyOut,   m0.keyout);
        check("i0_valid",  b0.KeyValid, (m0.gnt != 0));
        check("i0_count",  b0.Count,    mq0.size());
        check("i0_ovf",    b0.Overflow, m0.ovf);
        check("i1_keyrd",  b1.KeyRd,    m1.keyrd);
        check("i1_gnt",    b1.Gnt,      m1.gnt);
        check("i1_keyout", b1.KeyOut,   m1.keyout);
        check("i1_valid",  b1.KeyValid, (m1.gnt != 0));
        check("i1_count",  b1.Count,    mq1.size());
        check("i1_ovf",    b1.Overflow, m1.ovf);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(m0, mq0, 1'b0, b0.KeyRdy, b0.RowColVector, b0.Req, b0.OvfClr);
        model_step(m1, mq1, 1'b1, b1.KeyRdy, b1.RowColVector, b1.Req, b1.OvfClr);
        #1;
        compare_all();
    endtask

    task automatic set_rdy(input int k, input logic v, input logic [3:0] code);
        if (k == 0) begin b0.KeyRdy = v; b0.RowColVector = code; end
        else        begin b1.KeyRdy = v; b1.RowColVector = code; end
    endtask

    task automatic set_req(input int k, input logic [1:0] v);
        if (k == 0) b0.Req = v;
        else        b1.Req = v;
    endtask

    task automatic set_clr(input int k, input logic v);
        if (k == 0) b0.OvfClr = v;
        else        b1.OvfClr = v;
    endtask

    function automatic logic keyrd_of(input int k);
        return (k == 0) ? b0.KeyRd : b1.KeyRd;
    endfunction

    // Scanner model: raise KeyRdy, wait for the ack, drop KeyRdy, wait for release.
    task automatic send_key(input int k, input logic [3:0] code);
        bit seen;
        seen = 0;
        set_rdy(k, 1'b1, code);
        for (int n = 0; n < 16 && !seen; n++) begin
            tick();
            if (keyrd_of(k) === 1'b1) seen = 1;
        end
        check("hs_ack_seen", seen, 1);
        set_rdy(k, 1'b0, code);
        seen = 0;
        for (int n = 0; n < 16 && !seen; n++) begin
            tick();
            if (keyrd_of(k) === 1'b0) seen = 1;
        end
        check("hs_release_seen", seen, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        set_rdy(0, 1'b0, 4'h0); set_req(0, 2'b00); set_clr(0, 1'b0);
        set_rdy(1, 1'b0, 4'h0); set_req(1, 2'b00); set_clr(1, 1'b0);
        repeat (3) tick();
        check("rst_count", b0.Count, 0);
        check("rst_keyrd", b0.KeyRd, 0);
        check("rst_keyout", b0.KeyOut, 4'h0);
        rst = 1'b0;
        tick();

        // Scenario 1: single key through handshake and grant.
        set_rdy(0, 1'b1, 4'b0110);
        tick();
        check("s1_keyrd_up", b0.KeyRd, 1);
        check("s1_count1", b0.Count, 1);
        tick(); tick();
        check("s1_keyrd_held", b0.KeyRd, 1);
        set_rdy(0, 1'b0, 4'b0110);
        tick();
        check("s1_keyrd_down", b0.KeyRd, 0);
        set_req(0, 2'b01);
        tick();
        check("s1_gnt", b0.Gnt, 2'b01);
        check("s1_keyout", b0.KeyOut, 4'b0110);
        check("s1_count0", b0.Count, 0);
        set_req(0, 2'b00);
        tick();
        check("s1_keyout_hold", b0.KeyOut, 4'b0110);
        check("s1_gnt_off", b0.Gnt, 2'b00);

        // Scenario 2: fill, stall the fifth key, drain in order.
        for (int i = 0; i < 4; i++) send_key(0, 4'(i));
        check("s2_full", b0.Count, 4);
        set_rdy(0, 1'b1, 4'h4);
        repeat (3) tick();
        check("s2_stall_keyrd", b0.KeyRd, 0);
        check("s2_stall_count", b0.Count, 4);
        set_req(0, 2'b01);
        tick();
        check("s2_pop0_key", b0.KeyOut, 4'h0);
        check("s2_pop0_count", b0.Count, 3);
        check("s2_pop0_keyrd", b0.KeyRd, 0);
        set_req(0, 2'b00);
        tick();
        check("s2_push5_count", b0.Count, 4);
        check("s2_push5_keyrd", b0.KeyRd, 1);
        set_rdy(0, 1'b0, 4'h4);
        tick();
        set_req(0, 2'b01);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("s2_drain_key", b0.KeyOut, 4'(i));
        end
        set_req(0, 2'b00);
        tick();
        check("s2_empty", b0.Count, 0);

        // Scenario 3: drop-when-full instance, sticky Overflow and clear.
        for (int i = 0; i < 4; i++) send_key(1, 4'(i));
        set_rdy(1, 1'b1, 4'h4);
        tick();
        check("s3_drop_keyrd", b1.KeyRd, 1);
        check("s3_drop_ovf", b1.Overflow, 1);
        check("s3_drop_count", b1.Count, 4);
        set_rdy(1, 1'b0, 4'h4);
        tick();
        check("s3_ovf_sticky", b1.Overflow, 1);
        set_clr(1, 1'b1);
        tick();
        check("s3_ovf_clr", b1.Overflow, 0);
        set_rdy(1, 1'b1, 4'h5);
        tick();
        check("s3_set_wins", b1.Overflow, 1);
        set_rdy(1, 1'b0, 4'h5);
        set_clr(1, 1'b0);
        tick();
        set_req(1, 2'b10);
        repeat (4) tick();
        check("s3_last_key", b1.KeyOut, 4'h3);
        set_req(1, 2'b00);
        tick();
        check("s3_empty", b1.Count, 0);
        check("s0_never_ovf", b0.Overflow, 0);

        // Scenario 4: round-robin order across two requesters.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send_key(0, 4'hA);
        send_key(0, 4'hB);
        send_key(0, 4'hC);
        set_req(0, 2'b11);
        tick();
        check("s4_gnt1", b0.Gnt, 2'b01);
        check("s4_key1", b0.KeyOut, 4'hA);
        set_req(0, 2'b10);
        tick();
        check("s4_gnt2", b0.Gnt, 2'b10);
        check("s4_key2", b0.KeyOut, 4'hB);
        set_req(0, 2'b01);
        tick();
        check("s4_gnt3", b0.Gnt, 2'b01);
        check("s4_key3", b0.KeyOut, 4'hC);
        check("s4_empty", b0.Count, 0);
        set_req(0, 2'b00);
        tick();

        // Scenario 5: simultaneous push and pop at Count=2.
        send_key(0, 4'h5);
        send_key(0, 4'h6);
        check("s5_count2", b0.Count, 2);
        set_rdy(0, 1'b1, 4'h7);
        set_req(0, 2'b01);
        tick();
        check("s5_pp_count", b0.Count, 2);
        check("s5_pp_key", b0.KeyOut, 4'h5);
        set_req(0, 2'b00);
        set_rdy(0, 1'b0, 4'h7);
        tick();
        set_req(0, 2'b01);
        tick();
        check("s5_key6", b0.KeyOut, 4'h6);
        tick();
        check("s5_key7", b0.KeyOut, 4'h7);
        set_req(0, 2'b00);
        tick();

        // Scenario 6: repeated code inside and outside the hold window.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send_key(0, 4'b1001);
        repeat (5) tick();
        send_key(0, 4'b1001);
        check("s6_second", b0.Count, FILT ? 1 : 2);
        repeat (1100) tick();
        send_key(0, 4'b1001);
        check("s6_third", b0.Count, FILT ? 2 : 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
